// File: rtl/lane_reorder_stage.sv
// Byte-lane reordering stage with a two-entry elastic buffer on a valid/ready output.
// Optional stall counter port enabled by defining LANE_REORDER_DEBUG_EN.
module lane_reorder_stage #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [1:0]        in_mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
`ifdef LANE_REORDER_DEBUG_EN
  ,
  output logic [15:0]       debug_stall_cnt
`endif
);

  localparam int NB = DATA_W / 8;

  // Occupancy-encoded states
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  logic [DATA_W-1:0] rev_w;
  logic [DATA_W-1:0] swp_w;
  logic [DATA_W-1:0] rep_w;
  logic [DATA_W-1:0] xf_w;

  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_lane
      assign rev_w[gi*8 +: 8] = in_data[(NB-1-gi)*8 +: 8];
      assign swp_w[gi*8 +: 8] = in_data[(gi^1)*8 +: 8];
      assign rep_w[gi*8 +: 8] = in_data[7:0];
    end
  endgenerate

  always_comb begin
    case (in_mode)
      2'd0:    xf_w = in_data;
      2'd1:    xf_w = rev_w;
      2'd2:    xf_w = swp_w;
      default: xf_w = rep_w;
    endcase
  end

  logic [1:0]        state_reg;
  logic [1:0]        state_next;
  logic [DATA_W-1:0] head_reg;
  logic [DATA_W-1:0] head_next;
  logic [DATA_W-1:0] tail_reg;
  logic [DATA_W-1:0] tail_next;
  logic              in_ready_reg;
  logic              accept;
  logic              pop;

  assign accept    = in_valid && in_ready_reg;
  assign pop       = out_valid && out_ready;
  assign in_ready  = in_ready_reg;
  assign out_valid = (state_reg != ST_EMPTY);
  assign out_data  = head_reg;

  always_comb begin
    state_next = state_reg;
    head_next  = head_reg;
    tail_next  = tail_reg;
    case (state_reg)
      ST_EMPTY: begin
        if (accept) begin
          state_next = ST_ONE;
          head_next  = xf_w;
        end
      end
      ST_ONE: begin
        if (accept && !pop) begin
          state_next = ST_FULL;
          tail_next  = xf_w;
        end else if (!accept && pop) begin
          state_next = ST_EMPTY;
        end else if (accept && pop) begin
          head_next  = xf_w;
        end
      end
      ST_FULL: begin
        if (pop) begin
          state_next = ST_ONE;
          head_next  = tail_reg;
        end
      end
      default: state_next = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= ST_EMPTY;
      head_reg     <= '0;
      tail_reg     <= '0;
      in_ready_reg <= 1'b1;
    end else begin
      state_reg    <= state_next;
      head_reg     <= head_next;
      tail_reg     <= tail_next;
      // Registered copy of the next-state FULL decode keeps in_ready glitch-free
      in_ready_reg <= (state_next != ST_FULL);
    end
  end

`ifdef LANE_REORDER_DEBUG_EN
  logic [15:0] stall_cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_reg <= 16'h0000;
    end else if (out_valid && !out_ready && (stall_cnt_reg != 16'hFFFF)) begin
      stall_cnt_reg <= stall_cnt_reg + 16'd1;
    end
  end

  assign debug_stall_cnt = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_lane_reorder_stage.sv
// Directed, table-driven bench for lane_reorder_stage plus hand sequences for
// async reset and (with LANE_REORDER_DEBUG_EN) stall counter saturation.
module tb_lane_reorder_stage;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [1:0]  in_mode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
`ifdef LANE_REORDER_DEBUG_EN
  logic [15:0] debug_stall_cnt;
`endif

  lane_reorder_stage #(.DATA_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef LANE_REORDER_DEBUG_EN
    ,
    .debug_stall_cnt (debug_stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [31:0] d;
    logic [1:0]  m;
    logic        ordy;
    logic        e_ir;
    logic        e_ov;
    logic        chk_d;
    logic [31:0] e_od;
  } vec_t;

  localparam int NVEC = 16;
  vec_t vecs [NVEC];

  int n_cmp = 0;
  int n_err = 0;

  function automatic vec_t mk(input logic v, input logic [31:0] d, input logic [1:0] m,
                              input logic ordy, input logic e_ir, input logic e_ov,
                              input logic chk_d, input logic [31:0] e_od);
    vec_t r;
    r.v = v; r.d = d; r.m = m; r.ordy = ordy;
    r.e_ir = e_ir; r.e_ov = e_ov; r.chk_d = chk_d; r.e_od = e_od;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Drive inputs just after a rising edge, then sample 1ns after the next one
  task automatic cycle(input logic v, input logic [31:0] d, input logic [1:0] m, input logic ordy);
    in_valid  = v;
    in_data   = d;
    in_mode   = m;
    out_ready = ordy;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Mode coverage, back-to-back with out_ready high
    vecs[0]  = mk(1'b1, 32'h11223344, 2'd0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h11223344);
    vecs[1]  = mk(1'b1, 32'h11223344, 2'd1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h44332211);
    vecs[2]  = mk(1'b1, 32'h11223344, 2'd2, 1'b1, 1'b1, 1'b1, 1'b1, 32'h22114433);
    vecs[3]  = mk(1'b1, 32'h11223344, 2'd3, 1'b1, 1'b1, 1'b1, 1'b1, 32'h44444444);
    vecs[4]  = mk(1'b0, 32'h00000000, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h00000000);
    vecs[5]  = mk(1'b0, 32'hDEADBEEF, 2'd1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h00000000);
    // Backpressure: A, B absorbed, C held, then drained in order
    vecs[6]  = mk(1'b1, 32'hA0A1A2A3, 2'd0, 1'b0, 1'b1, 1'b1, 1'b1, 32'hA0A1A2A3);
    vecs[7]  = mk(1'b1, 32'hB0B1B2B3, 2'd1, 1'b0, 1'b0, 1'b1, 1'b1, 32'hA0A1A2A3);
    vecs[8]  = mk(1'b1, 32'hC0C1C2C3, 2'd2, 1'b0, 1'b0, 1'b1, 1'b1, 32'hA0A1A2A3);
    vecs[9]  = mk(1'b1, 32'hC0C1C2C3, 2'd2, 1'b1, 1'b1, 1'b1, 1'b1, 32'hB3B2B1B0);
    vecs[10] = mk(1'b1, 32'hC0C1C2C3, 2'd2, 1'b1, 1'b1, 1'b1, 1'b1, 32'hC1C0C3C2);
    vecs[11] = mk(1'b0, 32'h00000000, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h00000000);
    // Simultaneous accept and pop in ONE, then hold under stall
    vecs[12] = mk(1'b1, 32'h12345678, 2'd0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h12345678);
    vecs[13] = mk(1'b1, 32'h9ABCDEF0, 2'd3, 1'b1, 1'b1, 1'b1, 1'b1, 32'hF0F0F0F0);
    vecs[14] = mk(1'b0, 32'h00000000, 2'd0, 1'b0, 1'b1, 1'b1, 1'b1, 32'hF0F0F0F0);
    vecs[15] = mk(1'b0, 32'h00000000, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h00000000);

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_mode   = 2'd0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset in_ready",  {31'd0, in_ready},  32'd1);
    chk("reset out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset out_data",  out_data,           32'h0);
`ifdef LANE_REORDER_DEBUG_EN
    chk("reset stall_cnt", {16'd0, debug_stall_cnt}, 32'd0);
`endif
    rst = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      cycle(vecs[i].v, vecs[i].d, vecs[i].m, vecs[i].ordy);
      $display("vec %0d: v=%b d=%h m=%0d ordy=%b -> ir=%b ov=%b od=%h",
               i, vecs[i].v, vecs[i].d, vecs[i].m, vecs[i].ordy, in_ready, out_valid, out_data);
      chk($sformatf("vec%0d in_ready", i),  {31'd0, in_ready},  {31'd0, vecs[i].e_ir});
      chk($sformatf("vec%0d out_valid", i), {31'd0, out_valid}, {31'd0, vecs[i].e_ov});
      if (vecs[i].chk_d)
        chk($sformatf("vec%0d out_data", i), out_data, vecs[i].e_od);
    end

    // Async reset while FULL: outputs clear between edges, nothing replayed
    cycle(1'b1, 32'h55667788, 2'd0, 1'b0);
    cycle(1'b1, 32'h99AABBCC, 2'd0, 1'b0);
    chk("fill in_ready", {31'd0, in_ready}, 32'd0);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    $display("async reset: ir=%b ov=%b", in_ready, out_valid);
    chk("async rst out_valid", {31'd0, out_valid}, 32'd0);
    chk("async rst in_ready",  {31'd0, in_ready},  32'd1);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    cycle(1'b1, 32'h0F1E2D3C, 2'd0, 1'b1);
    $display("post-reset word: ov=%b od=%h", out_valid, out_data);
    chk("post rst out_valid", {31'd0, out_valid}, 32'd1);
    chk("post rst out_data",  out_data, 32'h0F1E2D3C);
    cycle(1'b0, 32'h0, 2'd0, 1'b1);
    chk("post rst alone", {31'd0, out_valid}, 32'd0);

`ifdef LANE_REORDER_DEBUG_EN
    rst = 1'b1;
    #2 rst = 1'b0;
    cycle(1'b1, 32'h01020304, 2'd0, 1'b0);
    in_valid = 1'b0;
    repeat (70000) @(posedge clk);
    #1;
    $display("stall counter after 70000 cycles: %h", debug_stall_cnt);
    chk("stall_cnt saturated", {16'd0, debug_stall_cnt}, 32'h0000FFFF);
    repeat (5) @(posedge clk);
    #1;
    chk("stall_cnt holds", {16'd0, debug_stall_cnt}, 32'h0000FFFF);
    chk("stall word held", out_data, 32'h01020304);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/lane_reorder_stage.md
# lane_reorder_stage

Byte-lane reordering stage with a two-entry elastic buffer. It sits directly downstream of the mode-driven data register stage. It accepts one DATA_W-bit word per cycle together with its 2-bit mode and applies the lane transform selected by that mode (pass, byte reverse, halfword byte swap, byte-0 replicate). It presents the result on a valid/ready output so that backpressure never drops or duplicates a word.

## Interface
- DATA_W, 32, data width in bits; must be a nonzero multiple of 16
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset, asynchronous, active-high
- in_valid  input  1  upstream word present
- in_ready  output  1  stage can accept a word this cycle
- in_data  input  DATA_W  upstream word
- in_mode  input  2  transform select, sampled with in_data
- out_valid  output  1  transformed word present
- out_ready  input  1  downstream accepts out_data this cycle
- out_data  output  DATA_W  transformed word
- debug_stall_cnt  output  16  only with LANE_REORDER_DEBUG_EN; stall-cycle counter

## Operation
- Accept = in_valid && in_ready. Pop = out_valid && out_ready.
- Transform is applied at accept time. Only the transformed word is stored.
  - Mode 0: pass through unchanged.
  - Mode 1: full byte reversal; byte k moves to byte (DATA_W/8-1-k).
  - Mode 2: the two bytes of every 16-bit halfword are swapped; halfword order is preserved.
  - Mode 3: in_data[7:0] is replicated into every byte lane.
- Buffer: two registers, head and tail. out_data is always the head.
- State machine, occupancy-encoded:
  - EMPTY: accept moves to ONE; the word is written to the head.
  - ONE, accept without pop: moves to FULL; the word is written to the tail.
  - ONE, pop without accept: moves to EMPTY.
  - ONE, accept and pop: stays in ONE; the new word is written to the head.
  - FULL, pop: the tail moves to the head and the state moves to ONE. No accept is possible in FULL.
- Words leave strictly in acceptance order. No word is dropped or duplicated.
- in_ready = (state != FULL) and is driven from a register. out_valid = (state != EMPTY).
- in_data and in_mode are ignored when in_valid is low. out_data holds its value while out_valid && !out_ready.

## Timing
- Reset values: state EMPTY, in_ready 1, out_valid 0, out_data 0, debug_stall_cnt 0.
- Reset asserted mid-operation discards all buffered words immediately; nothing is replayed.
- Latency: a word accepted in cycle N appears on out_data with out_valid high in cycle N+1.
- Throughput: one word per cycle whenever out_ready stays high; in_ready never drops in that case.
- Backpressure: with out_ready low, two words are absorbed. in_ready is low from the cycle after the second accept.
- From FULL, the first pop raises in_ready in the next cycle. The tail word is presented on out_data in that same next cycle.
- Simultaneous accept and pop in ONE keeps occupancy at one, and in_ready stays high.

## Configuration
- LANE_REORDER_DEBUG_EN defined:
  - Adds the debug_stall_cnt port.
  - The counter increments on every cycle where out_valid && !out_ready.
  - It saturates at 16'hFFFF and clears only on rst.
- LANE_REORDER_DEBUG_EN undefined: the port and counter are absent. Datapath and handshake behaviour are identical in both builds.

## Test plan
- Mode coverage, out_ready held high, in_data 32'h11223344:
  - Mode 0 gives 32'h11223344.
  - Mode 1 gives 32'h44332211.
  - Mode 2 gives 32'h22114433.
  - Mode 3 gives 32'h44444444.
  - Each result appears one cycle after accept, back-to-back with no bubbles.
- Backpressure: out_ready low; send A, B, C on consecutive cycles.
  - A and B are accepted. in_ready falls and C is held upstream.
  - Raise out_ready: A, B, C emerge in order, and in_ready returns high one cycle after A's pop.
- Simultaneous event: in state ONE, assert accept and pop in the same cycle. Occupancy stays one, and the new word is on out_data in the next cycle.
- Reset mid-operation: fill to FULL, then assert rst asynchronously between clock edges.
  - out_valid goes to 0 and in_ready to 1 without waiting for a clock edge.
  - The first post-reset word is output alone.
- Debug build: hold out_ready low for 70000 cycles with one word buffered. debug_stall_cnt reads 16'hFFFF and stays there. The non-debug build passes all the other scenarios unchanged.
